// File: rtl/sr_context_stack_if.sv
// Save/restore handshake bundle between the controller/status register and
// the {C,Z} context stack. master = controller side, slave = stack side.
interface sr_context_stack_if;
    logic Cflag;
    logic Zflag;
    logic push;
    logic pop;
    logic clr_err;
    logic Crestore;
    logic Zrestore;
    logic SRload;
    logic empty;
    logic full;
    logic ovf_err;
    logic unf_err;

    modport master (
        output Cflag, Zflag, push, pop, clr_err,
        input  Crestore, Zrestore, SRload,
        input  empty, full, ovf_err, unf_err
    );

    modport slave (
        input  Cflag, Zflag, push, pop, clr_err,
        output Crestore, Zrestore, SRload,
        output empty, full, ovf_err, unf_err
    );
endinterface

// File: rtl/sr_context_stack.sv
// sr_context_stack: LIFO save/restore of the SAYEH {C,Z} status flags.
// Pushes live flags on entry, pops them back through the SR parallel-load
// path (Crestore/Zrestore + SRload, registered, high for the restore cycle).
// Ports: clk, rst (sync, active-high), sr (slave modport of
//   sr_context_stack_if: Cflag/Zflag/push/pop/clr_err in;
//   Crestore/Zrestore/SRload/empty/full/ovf_err/unf_err out).
// Build option: define SR_STACK_WRAP_EN to make a push while full overwrite
//   the oldest entry instead of being discarded with ovf_err.
module sr_context_stack #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input logic          clk,
    input logic          rst,
    sr_context_stack_if.slave sr
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOAD = 1'b1;

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   ONE_C    = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] ONE_P    = PTR_W'(1);

    logic [1:0]       r_mem [DEPTH];
    logic [PTR_W:0]   r_count;
    logic [PTR_W-1:0] r_base;
    logic [0:0]       r_state;
    logic             r_crest;
    logic             r_zrest;
    logic             r_empty;
    logic             r_full;
    logic             r_ovf;
    logic             r_unf;

    logic             w_has;
    logic             w_is_full;
    logic             w_pop_ok;
    logic [PTR_W-1:0] w_top;
    logic [PTR_W-1:0] w_tail;
    logic [1:0]       w_flags;
    logic [PTR_W:0]   w_count_nxt;
    logic [PTR_W-1:0] w_base_nxt;
    logic             w_wr_en;
    logic [PTR_W-1:0] w_wr_addr;
    logic             w_ovf_set;
    logic             w_unf_set;

    assign w_has     = (r_count != '0);
    assign w_is_full = (r_count == FULL_CNT);
    assign w_pop_ok  = sr.pop && w_has;
    assign w_flags   = {sr.Cflag, sr.Zflag};

    // Physical slots are base-relative; indices wrap naturally mod DEPTH.
    // When full, w_tail lands on the oldest entry (base).
    assign w_top  = r_base + r_count[PTR_W-1:0] - ONE_P;
    assign w_tail = r_base + r_count[PTR_W-1:0];

    always_comb begin
        w_count_nxt = r_count;
        w_base_nxt  = r_base;
        w_wr_en     = 1'b0;
        w_wr_addr   = w_tail;
        w_ovf_set   = 1'b0;
        w_unf_set   = 1'b0;
        unique case (1'b1)
            (w_pop_ok && sr.push): begin
                // swap: old top goes out, live flags replace it
                w_wr_en   = 1'b1;
                w_wr_addr = w_top;
            end
            (w_pop_ok && !sr.push): begin
                w_count_nxt = r_count - ONE_C;
            end
            (!w_pop_ok && sr.push && !w_is_full): begin
                w_wr_en     = 1'b1;
                w_count_nxt = r_count + ONE_C;
            end
            (!w_pop_ok && sr.push && w_is_full): begin
`ifdef SR_STACK_WRAP_EN
                w_wr_en    = 1'b1;
                w_base_nxt = r_base + ONE_P;
`else
                w_ovf_set  = 1'b1;
`endif
            end
            (sr.pop && !w_has && !sr.push): begin
                w_unf_set = 1'b1;
            end
            default: ;
        endcase
    end

    // Storage has no reset; contents are don't-care after rst.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_en) begin
            r_mem[w_wr_addr] <= w_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_base  <= '0;
            r_state <= ST_IDLE;
            r_crest <= 1'b0;
            r_zrest <= 1'b0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_base  <= w_base_nxt;
            r_state <= w_pop_ok ? ST_LOAD : ST_IDLE;
            if (w_pop_ok) begin
                {r_crest, r_zrest} <= r_mem[w_top];
            end
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == FULL_CNT);
            // a new error in the clearing cycle survives the clear
            r_ovf   <= w_ovf_set | (r_ovf & ~sr.clr_err);
            r_unf   <= w_unf_set | (r_unf & ~sr.clr_err);
        end
    end

    assign sr.Crestore = r_crest;
    assign sr.Zrestore = r_zrest;
    assign sr.SRload   = (r_state == ST_LOAD);
    assign sr.empty    = r_empty;
    assign sr.full     = r_full;
    assign sr.ovf_err  = r_ovf;
    assign sr.unf_err  = r_unf;

endmodule

// File: tb/tb_sr_context_stack.sv
// Directed + random bench for sr_context_stack against a queue-based
// reference model of the {C,Z} save/restore stack.
module tb_sr_context_stack;

    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    sr_context_stack_if bus ();

    sr_context_stack #(
        .DEPTH (DEPTH),
        .PTR_W (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sr  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] mq [$];
    logic       m_c;
    logic       m_z;
    logic       m_ld;
    logic       m_ovf;
    logic       m_unf;

    task automatic chk(input string tag, input logic [1:0] obs,
                       input logic [1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model(input logic p, input logic q, input logic clr,
                         input logic [1:0] f, input logic r);
        logic no;
        logic nu;
        if (r) begin
            mq.delete();
            m_c = 0; m_z = 0; m_ld = 0; m_ovf = 0; m_unf = 0;
            return;
        end
        no = 0;
        nu = 0;
        m_ld = 0;
        if (q && mq.size() > 0) begin
            {m_c, m_z} = mq[$];
            m_ld = 1;
            if (p) mq[$] = f;
            else void'(mq.pop_back());
        end else if (p) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(f);
            end else begin
`ifdef SR_STACK_WRAP_EN
                void'(mq.pop_front());
                mq.push_back(f);
`else
                no = 1;
`endif
            end
        end else if (q) begin
            nu = 1;
        end
        m_ovf = no | (m_ovf & ~clr);
        m_unf = nu | (m_unf & ~clr);
    endtask

    task automatic check_all();
        chk("SRload", {1'b0, bus.SRload}, {1'b0, m_ld});
        chk("restore", {bus.Crestore, bus.Zrestore}, {m_c, m_z});
        chk("empty", {1'b0, bus.empty}, {1'b0, mq.size() == 0});
        chk("full", {1'b0, bus.full}, {1'b0, mq.size() == DEPTH});
        chk("ovf_err", {1'b0, bus.ovf_err}, {1'b0, m_ovf});
        chk("unf_err", {1'b0, bus.unf_err}, {1'b0, m_unf});
    endtask

    task automatic step(input logic p, input logic q, input logic clr,
                        input logic [1:0] f, input logic r);
        bus.push    = p;
        bus.pop     = q;
        bus.clr_err = clr;
        {bus.Cflag, bus.Zflag} = f;
        rst = r;
        @(posedge clk);
        model(p, q, clr, f, r);
        #1;
        check_all();
    endtask

    task automatic rest(input string tag, input logic [1:0] exp);
        chk(tag, {bus.Crestore, bus.Zrestore}, exp);
    endtask

    initial begin
        logic [1:0] t5 [4];
        n_chk = 0;
        n_err = 0;
        rst = 1;
        bus.push = 0; bus.pop = 0; bus.clr_err = 0;
        bus.Cflag = 0; bus.Zflag = 0;

        // T1 reset
        step(0, 0, 0, 2'b00, 1);
        step(0, 0, 0, 2'b00, 1);

        // T2 LIFO
        step(1, 0, 0, 2'b10, 0);
        step(1, 0, 0, 2'b01, 0);
        step(1, 0, 0, 2'b11, 0);
        step(0, 1, 0, 2'b00, 0); rest("T2_pop1", 2'b11);
        step(0, 1, 0, 2'b00, 0); rest("T2_pop2", 2'b01);
        step(0, 1, 0, 2'b00, 0); rest("T2_pop3", 2'b10);
        step(0, 0, 0, 2'b00, 0);

        // T3 swap
        step(1, 0, 0, 2'b10, 0);
        step(1, 1, 0, 2'b01, 0); rest("T3_swap", 2'b10);
        step(0, 1, 0, 2'b00, 0); rest("T3_pop", 2'b01);
        step(0, 0, 0, 2'b00, 0);

        // T4 underflow, push+pop while empty, clear
        step(0, 1, 0, 2'b00, 0);
        step(0, 0, 1, 2'b00, 0);
        step(1, 1, 0, 2'b11, 0);
        step(0, 1, 0, 2'b00, 0); rest("T4_pop", 2'b11);
        step(0, 1, 1, 2'b00, 0);
        step(0, 0, 0, 2'b00, 0);

        // T5 overflow
        step(1, 0, 0, 2'b00, 0);
        step(1, 0, 0, 2'b01, 0);
        step(1, 0, 0, 2'b10, 0);
        step(1, 0, 0, 2'b11, 0);
        step(1, 0, 0, 2'b01, 0);
`ifdef SR_STACK_WRAP_EN
        t5[0] = 2'b01; t5[1] = 2'b11; t5[2] = 2'b10; t5[3] = 2'b01;
        chk("T5_ovf", {1'b0, bus.ovf_err}, 2'b00);
`else
        t5[0] = 2'b11; t5[1] = 2'b10; t5[2] = 2'b01; t5[3] = 2'b00;
        chk("T5_ovf", {1'b0, bus.ovf_err}, 2'b01);
`endif
        chk("T5_full", {1'b0, bus.full}, 2'b01);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 2'b00, 0);
            rest("T5_pop", t5[i]);
        end
        step(0, 0, 1, 2'b00, 0);

        // T6 reset mid-restore
        step(1, 0, 0, 2'b11, 0);
        step(1, 0, 0, 2'b10, 0);
        step(0, 1, 0, 2'b00, 0);
        step(0, 1, 0, 2'b00, 1);
        step(0, 1, 0, 2'b00, 0);
        chk("T6_unf", {1'b0, bus.unf_err}, 2'b01);

        // random
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 45,
                 $urandom_range(0, 99) < 8,
                 2'($urandom),
                 $urandom_range(0, 99) < 2);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
